// File: rtl/div8_seq.sv
// div8_seq: multi-cycle unsigned restoring divider.
// It produces one quotient bit per clock and needs WIDTH iterations.
// A divide by zero skips the iterations. It finishes on the next edge
// with q = all ones, r = a and dz = 1.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | iterating, one trial subtraction per clock, busy = 1
// DONE  | done pulse cycle; start is accepted here like in IDLE
module div8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;

    // Trial subtraction for the current iteration. The partial remainder
    // stays below 2^(k-1) before iteration k, so its top bit is always
    // clear here. Using the full register keeps the result exact anyway.
    always_comb begin
        trial     = {rem, dividend[WIDTH-1]} - {1'b0, divisor};
        qbit      = ~trial[WIDTH];
        rem_next  = qbit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dividend[WIDTH-1]};
        quot_next = {quot[WIDTH-2:0], qbit};
    end

    // Control FSM, working registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            dz       <= 1'b0;
            q        <= '0;
            r        <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quot     <= '0;
            count    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (b == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            q     <= '1;
                            r     <= a;
                            dz    <= 1'b1;
                        end else begin
                            state    <= S_RUN;
                            busy     <= 1'b1;
                            dividend <= a;
                            divisor  <= b;
                            rem      <= '0;
                            quot     <= '0;
                            count    <= '0;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    dividend <= {dividend[WIDTH-2:0], 1'b0};
                    rem      <= rem_next;
                    quot     <= quot_next;
                    count    <= count + 1'b1;
                    // The results are loaded from the last iteration's
                    // next-state values, so they appear together with done.
                    if (count == LAST_ITER) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        q     <= quot_next;
                        r     <= rem_next;
                        dz    <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div8_seq.sv
// Testbench for div8_seq. It runs a table of known quotients, then the
// multi-cycle corner sequences, then random operands checked against
// plain integer division.
module tb_div8_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;

    int total = 0;
    int bad   = 0;

    div8_seq #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .q    (q),
        .r    (r),
        .dz   (dz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         edges;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Launches one operation from IDLE and waits for done. edges is the
    // number of clock edges after the accepting edge at which done shows
    // (-1 on timeout). busy_cyc counts the sampled cycles with busy high
    // before done.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [7:0] oq, output logic [7:0] orr,
                          output logic odz, output int edges, output int busy_cyc);
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        edges    = -1;
        busy_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                edges = i;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
        oq  = q;
        orr = r;
        odz = dz;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    vec_t       vecs[10];
    logic [7:0] gq, gr;
    logic       gdz;
    int         ged, gbusy;
    logic [7:0] hold_q, hold_r;
    int         unstable;
    int         seen_done;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8};
        vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8};
        vecs[4] = '{8'h5A,  8'd0,   8'hFF,  8'h5A,  1'b1, 0};
        vecs[5] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 8};
        vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
        vecs[7] = '{8'd128, 8'd200, 8'd0,   8'd128, 1'b0, 8};
        vecs[8] = '{8'd255, 8'd128, 8'd1,   8'd127, 1'b0, 8};
        vecs[9] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 0};

        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz",   {31'd0, dz},   32'd0);
        check("rst_q",    {24'd0, q},    32'd0);
        check("rst_r",    {24'd0, r},    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of directed vectors.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, gq, gr, gdz, ged, gbusy);
            check("vec_q",     {24'd0, gq},  {24'd0, vecs[i].q});
            check("vec_r",     {24'd0, gr},  {24'd0, vecs[i].r});
            check("vec_dz",    {31'd0, gdz}, {31'd0, vecs[i].dz});
            check("vec_edges", ged,          vecs[i].edges);
            check("vec_busy",  gbusy,        vecs[i].edges);
        end

        // start during RUN is ignored; q/r hold the previous result until done.
        @(negedge clk);
        a     = 8'd100;
        b     = 8'd10;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        hold_q = q;
        hold_r = r;
        unstable = 0;
        ged = -1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ged = i;
                break;
            end
            if (q !== hold_q || r !== hold_r) unstable++;
            if (i == 2) begin
                start = 1'b1;
                a     = 8'd1;
                b     = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_hold",  unstable,     0);
        check("ign_edges", ged,          8);
        check("ign_q",     {24'd0, q},   32'd10);
        check("ign_r",     {24'd0, r},   32'd0);
        check("ign_dz",    {31'd0, dz},  32'd0);
        @(negedge clk);
        check("ign_done_one_cycle", {31'd0, done}, 32'd0);

        // start held high through the DONE cycle: back-to-back with no bubble.
        @(negedge clk);
        a     = 8'd100;
        b     = 8'd10;
        start = 1'b1;
        @(negedge clk);
        a   = 8'd17;
        b   = 8'd5;
        ged = -1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ged = i;
                break;
            end
            @(negedge clk);
        end
        check("b2b_first_edges", ged,        8);
        check("b2b_first_q",     {24'd0, q}, 32'd10);
        check("b2b_first_r",     {24'd0, r}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        check("b2b_accept_done", {31'd0, done}, 32'd0);
        ged = -1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ged = i;
                break;
            end
            @(negedge clk);
        end
        check("b2b_second_edges", ged,         8);
        check("b2b_second_q",     {24'd0, q},  32'd3);
        check("b2b_second_r",     {24'd0, r},  32'd2);
        check("b2b_second_dz",    {31'd0, dz}, 32'd0);
        @(negedge clk);

        // Reset in the middle of RUN aborts with no done pulse.
        @(negedge clk);
        a     = 8'd200;
        b     = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_q",    {24'd0, q},    32'd0);
        check("mid_rst_r",    {24'd0, r},    32'd0);
        check("mid_rst_dz",   {31'd0, dz},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("mid_no_done", seen_done, 0);
        run_op(8'd200, 8'd7, gq, gr, gdz, ged, gbusy);
        check("mid_after_q",     {24'd0, gq},  32'd28);
        check("mid_after_r",     {24'd0, gr},  32'd4);
        check("mid_after_dz",    {31'd0, gdz}, 32'd0);
        check("mid_after_edges", ged,          8);

        // Random operands against integer division.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            int eq, er, edz;
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (rb == 8'd0) begin
                eq  = 255;
                er  = int'(ra);
                edz = 1;
            end else begin
                eq  = int'(ra) / int'(rb);
                er  = int'(ra) % int'(rb);
                edz = 0;
            end
            run_op(ra, rb, gq, gr, gdz, ged, gbusy);
            check("rnd_q",     {24'd0, gq},  eq);
            check("rnd_r",     {24'd0, gr},  er);
            check("rnd_dz",    {31'd0, gdz}, edz);
            check("rnd_edges", ged,          (rb == 8'd0) ? 0 : 8);
            if (!gdz) begin
                check("rnd_identity", int'(gq) * int'(rb) + int'(gr), int'(ra));
                check("rnd_r_lt_b",   {31'd0, (gr < rb)}, 32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
